// File: rtl/window_spill_fill.sv
// Register-window spill/fill engine: moves the 16 windowed registers of one window
// between the register file and the stack, then publishes the new WIM value.
//   state  | meaning
//   IDLE   | waiting for spill_req / fill_req
//   SP_RD  | read register idx of the window
//   SP_LAT | capture register read data
//   SP_MEM | store word idx to the stack
//   FL_MEM | load word idx from the stack
//   FL_WR  | write loaded word into register idx
//   DONE   | completion pulse, WIM update
module window_spill_fill #(
  parameter int NWINDOWS = 32,
  parameter int WORD     = 32,
  parameter int ADDR     = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            spill_req,
  input  logic            fill_req,
  input  logic [4:0]      req_win,
  input  logic [ADDR-1:0] base_addr,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            rf_rd_en,
  output logic [4:0]      rf_rd_win,
  output logic [3:0]      rf_rd_idx,
  input  logic [WORD-1:0] rf_rd_data,
  output logic            rf_wr_en,
  output logic [4:0]      rf_wr_win,
  output logic [3:0]      rf_wr_idx,
  output logic [WORD-1:0] rf_wr_data,
  output logic            mem_req,
  output logic            mem_we,
  output logic [ADDR-1:0] mem_addr,
  output logic [WORD-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [WORD-1:0] mem_rdata,
  output logic            wim_we,
  output logic [31:0]     wim_out
);

  typedef enum logic [2:0] {IDLE, SP_RD, SP_LAT, SP_MEM, FL_MEM, FL_WR, DONE} state_t;

  localparam logic [4:0] WIN_MASK = 5'(NWINDOWS - 1);

  state_t          state_q, state_d;
  logic            spill_q, err_q;
  logic [4:0]      win_q;
  logic [3:0]      idx_q;
  logic [ADDR-1:0] addr_q;
  logic [WORD-1:0] data_q;
  logic [31:0]     wim_q;
  logic            accept, advance, misaligned, last_word;
  logic [4:0]      fill_win;

  assign misaligned = base_addr[1:0] != 2'b00;
  assign last_word  = idx_q == 4'd15;
  // A fill restores the window below, so the invalid mark moves one window down.
  assign fill_win   = (win_q - 5'd1) & WIN_MASK;

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    advance  = 1'b0;
    rf_rd_en = 1'b0;
    rf_wr_en = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    wim_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (spill_req || fill_req) begin
          accept = 1'b1;
          if (misaligned)     state_d = DONE;
          else if (spill_req) state_d = SP_RD;
          else                state_d = FL_MEM;
        end
      end
      SP_RD: begin
        rf_rd_en = 1'b1;
        state_d  = SP_LAT;
      end
      SP_LAT: state_d = SP_MEM;
      SP_MEM: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) begin
          if (last_word) state_d = DONE;
          else begin
            advance = 1'b1;
            state_d = SP_RD;
          end
        end
      end
      FL_MEM: begin
        mem_req = 1'b1;
        if (mem_ack) state_d = FL_WR;
      end
      FL_WR: begin
        rf_wr_en = 1'b1;
        if (last_word) state_d = DONE;
        else begin
          advance = 1'b1;
          state_d = FL_MEM;
        end
      end
      DONE: begin
        done    = 1'b1;
        err     = err_q;
        wim_we  = !err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      spill_q <= 1'b0;
      err_q   <= 1'b0;
      win_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wim_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        spill_q <= spill_req;
        err_q   <= misaligned;
        idx_q   <= '0;
        if (!misaligned) begin
          win_q  <= req_win & WIN_MASK;
          addr_q <= base_addr;
        end
      end
      if (advance) begin
        idx_q  <= idx_q + 4'd1;
        addr_q <= addr_q + ADDR'(4);
      end
      if (state_q == SP_LAT) data_q <= rf_rd_data;
      if (state_q == FL_MEM && mem_ack) data_q <= mem_rdata;
      if (state_q != IDLE && state_q != DONE && state_d == DONE)
        wim_q <= spill_q ? (32'd1 << win_q) : (32'd1 << fill_win);
    end
  end

  assign busy       = state_q != IDLE;
  assign rf_rd_win  = win_q;
  assign rf_rd_idx  = idx_q;
  assign rf_wr_win  = win_q;
  assign rf_wr_idx  = idx_q;
  assign rf_wr_data = data_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = data_q;
  assign wim_out    = wim_q;

endmodule
